// File: rtl/atm_pkg.sv
// Shared definitions for the ATM customer-side session driver:
// default widths, operation codes, response status and FSM state encodings.
package atm_pkg;

    localparam int PASSWORD_W = 4;
    localparam int BALANCE_W  = 20;
    localparam int CARD_W     = 3;

    localparam logic [1:0] OP_DEPOSIT  = 2'b00;
    localparam logic [1:0] OP_WITHDRAW = 2'b01;
    localparam logic [1:0] OP_INQUIRY  = 2'b10;

    typedef enum logic [1:0] {
        ST_OK        = 2'b00,
        ST_ERROR     = 2'b01,
        ST_WRONG_PSW = 2'b10,
        ST_TIMEOUT   = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_RESP,
        S_NEXT,
        S_EJECT
    } state_e;

    // Map simultaneous ATM flags to one status: wrong_psw beats error beats op_done.
    function automatic status_e resolve_outcome(input logic wrong, input logic err);
        if (wrong) return ST_WRONG_PSW;
        if (err)   return ST_ERROR;
        return ST_OK;
    endfunction

endpackage

// File: rtl/atm_timeout_cnt.sv
// Clearable saturating cycle counter; expired is high once TIMEOUT-1 enabled
// cycles have elapsed since the last clear, so the TIMEOUT-th waiting cycle
// sees it asserted. The count parks at its limit instead of wrapping.
module atm_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] cnt;

    // Count enabled cycles, restart on clear, hold at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/atm_session_driver.sv
// Customer-side initiator for ATM_Top: takes one host request at a time,
// drives the ATM customer inputs, waits for the outcome, returns a status,
// and manages card insertion, wrong-PIN retries, timeout and ejection.
module atm_session_driver
    import atm_pkg::*;
#(
    parameter int password_width = 4,
    parameter int balance_width  = 20,
    parameter int card_width     = 3,
    parameter int TIMEOUT        = 16,
    parameter int MAX_TRIES      = 3,
    parameter int EJECT_CYCLES   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [card_width-1:0]     req_card,
    input  logic [password_width-1:0] req_psw,
    input  logic                      req_lang,
    input  logic [1:0]                req_op,
    input  logic [balance_width-1:0]  req_value,
    input  logic                      req_last,
    output logic [card_width-1:0]     card_number,
    output logic [password_width-1:0] password_input,
    output logic                      card_out,
    output logic                      language,
    output logic [1:0]                operation,
    output logic [balance_width-1:0]  value,
    output logic                      another_service,
    input  logic [balance_width-1:0]  updated_balance,
    input  logic                      op_done,
    input  logic                      error,
    input  logic                      wrong_psw,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [1:0]                rsp_status,
    output logic [balance_width-1:0]  rsp_balance,
    output logic                      busy
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int EJ_W  = $clog2(EJECT_CYCLES + 1);

    state_e           state;
    status_e          status_q;
    logic [TRY_W-1:0] tries;
    logic [EJ_W-1:0]  ej_cnt;
    logic             last_q;
    logic             tmo_expired;
    logic             any_flag;

    assign req_ready  = (state == S_IDLE) || (state == S_NEXT);
    assign rsp_status = status_q;
    assign any_flag   = wrong_psw | error | op_done;

    atm_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == S_DRIVE),
        .en      (state == S_WAIT),
        .expired (tmo_expired)
    );

    // Session FSM with registered ATM-side and host-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            card_number     <= '0;
            password_input  <= '0;
            card_out        <= 1'b1;
            language        <= 1'b0;
            operation       <= '0;
            value           <= '0;
            another_service <= 1'b0;
            rsp_valid       <= 1'b0;
            status_q        <= ST_OK;
            rsp_balance     <= '0;
            busy            <= 1'b0;
            tries           <= '0;
            ej_cnt          <= '0;
            last_q          <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_NEXT: begin
                    if (req_valid) begin
                        // The card number belongs to the session, not the request.
                        if (state == S_IDLE) card_number <= req_card;
                        password_input  <= req_psw;
                        language        <= req_lang;
                        operation       <= req_op;
                        value           <= req_value;
                        another_service <= !req_last;
                        last_q          <= req_last;
                        card_out        <= 1'b0;
                        busy            <= 1'b1;
                        state           <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (any_flag) begin
                        status_q    <= resolve_outcome(wrong_psw, error);
                        rsp_balance <= (!wrong_psw && !error) ? updated_balance : '0;
                        if (wrong_psw) tries <= tries + 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= S_RESP;
                    end else if (tmo_expired) begin
                        status_q    <= ST_TIMEOUT;
                        rsp_balance <= '0;
                        rsp_valid   <= 1'b1;
                        state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if ((status_q == ST_TIMEOUT) || (tries == TRY_W'(MAX_TRIES)) || last_q) begin
                            card_number     <= '0;
                            password_input  <= '0;
                            card_out        <= 1'b1;
                            language        <= 1'b0;
                            operation       <= '0;
                            value           <= '0;
                            another_service <= 1'b0;
                            ej_cnt          <= '0;
                            state           <= S_EJECT;
                        end else begin
                            state <= S_NEXT;
                        end
                    end
                end
                S_EJECT: begin
                    if (ej_cnt == EJ_W'(EJECT_CYCLES - 1)) begin
                        tries <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        ej_cnt <= ej_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atm_session_driver.sv
// Randomized bench for atm_session_driver with a behavioural ATM and
// session model (balances, PINs, retry count, eject decision).
module tb_atm_session_driver;
    import atm_pkg::*;

    localparam int CW   = 3;
    localparam int PW   = 4;
    localparam int BW   = 20;
    localparam int TMO  = 16;
    localparam int MAXT = 3;
    localparam int EJC  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready;
    logic [CW-1:0] req_card;
    logic [PW-1:0] req_psw;
    logic          req_lang;
    logic [1:0]    req_op;
    logic [BW-1:0] req_value;
    logic          req_last;
    logic [CW-1:0] card_number;
    logic [PW-1:0] password_input;
    logic          card_out, language, another_service;
    logic [1:0]    operation;
    logic [BW-1:0] value, updated_balance;
    logic          op_done, error, wrong_psw;
    logic          rsp_valid, rsp_ready, busy;
    logic [1:0]    rsp_status;
    logic [BW-1:0] rsp_balance;

    always #5 clk = ~clk;

    atm_session_driver #(
        .password_width (PW), .balance_width (BW), .card_width (CW),
        .TIMEOUT (TMO), .MAX_TRIES (MAXT), .EJECT_CYCLES (EJC)
    ) dut (
        .clk (clk), .rst (rst),
        .req_valid (req_valid), .req_ready (req_ready), .req_card (req_card),
        .req_psw (req_psw), .req_lang (req_lang), .req_op (req_op),
        .req_value (req_value), .req_last (req_last),
        .card_number (card_number), .password_input (password_input),
        .card_out (card_out), .language (language), .operation (operation),
        .value (value), .another_service (another_service),
        .updated_balance (updated_balance), .op_done (op_done), .error (error),
        .wrong_psw (wrong_psw),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_status (rsp_status),
        .rsp_balance (rsp_balance), .busy (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural ATM and session state
    logic [BW-1:0] bal [8];
    logic [PW-1:0] pin [8];
    bit            in_sess = 0;
    logic [CW-1:0] sess_card;
    int            tries_m = 0;

    function automatic logic [CW-1:0] cur_card(input logic [CW-1:0] card);
        return in_sess ? sess_card : card;
    endfunction

    task automatic run_req(input logic [CW-1:0] card, input logic [PW-1:0] psw,
                           input logic lang, input logic [1:0] op,
                           input logic [BW-1:0] val, input logic last,
                           input bit no_answer, input int delay, input int hold);
        logic [CW-1:0] c;
        logic [1:0]    exp_st;
        logic [BW-1:0] exp_bal;
        bit            w, e, d, ej;
        int            k, exp_k;

        if (!in_sess) begin
            sess_card = card;
            in_sess   = 1;
        end
        c = sess_card;
        w = 0; e = 0; d = 0; exp_bal = '0;
        if (no_answer) begin
            exp_st = ST_TIMEOUT;
        end else if (psw != pin[c]) begin
            exp_st = ST_WRONG_PSW;
            w = 1; e = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1));
            tries_m++;
        end else if (op == OP_WITHDRAW && val > bal[c]) begin
            exp_st = ST_ERROR;
            e = 1; d = 1;
        end else begin
            exp_st = ST_OK;
            d = 1;
            if (op == OP_DEPOSIT)       bal[c] = bal[c] + val;
            else if (op == OP_WITHDRAW) bal[c] = bal[c] - val;
            exp_bal = bal[c];
        end
        ej = no_answer || (tries_m == MAXT) || last;

        @(negedge clk);
        check("req_ready_before", req_ready, 1);
        req_card = card; req_psw = psw; req_lang = lang; req_op = op;
        req_value = val; req_last = last; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        req_card  = CW'($urandom);
        check("card_number", card_number, c);
        check("password_input", password_input, psw);
        check("card_out_drive", card_out, 0);
        check("language", language, lang);
        check("operation", operation, op);
        check("value", value, val);
        check("another_service", another_service, !last);
        check("busy_drive", busy, 1);
        // A flag during the DRIVE cycle must be ignored.
        op_done = 1'($urandom_range(0, 1));

        exp_k = no_answer ? TMO + 1 : delay + 2;
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            op_done = 0; error = 0; wrong_psw = 0;
            updated_balance = BW'($urandom);
            if (rsp_valid) break;
            if (!no_answer && k == delay + 1) begin
                wrong_psw = w; error = e; op_done = d;
                if (exp_st == ST_OK) updated_balance = exp_bal;
            end
        end
        check("rsp_latency", k, exp_k);
        check("rsp_status", rsp_status, exp_st);
        check("rsp_balance", rsp_balance, exp_bal);
        check("card_held_wait", card_number, c);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_status", rsp_status, exp_st);
            check("hold_balance", rsp_balance, exp_bal);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check("rsp_valid_after", rsp_valid, 0);

        if (ej) begin
            for (int i = 0; i < EJC; i++) begin
                check("eject_card_out", card_out, 1);
                check("eject_ready", req_ready, 0);
                check("eject_busy", busy, 1);
                @(negedge clk);
            end
            check("idle_ready", req_ready, 1);
            check("idle_busy", busy, 0);
            check("idle_card_out", card_out, 1);
            in_sess = 0;
            tries_m = 0;
        end else begin
            check("next_card_out", card_out, 0);
            check("next_ready", req_ready, 1);
            check("next_busy", busy, 1);
            check("next_card", card_number, c);
        end
    endtask

    task automatic reset_mid_wait(input logic [CW-1:0] card);
        int vcount;
        @(negedge clk);
        req_card = card; req_psw = pin[card]; req_lang = 0; req_op = OP_INQUIRY;
        req_value = '0; req_last = 1; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1;
        rsp_ready = 1;
        #1;
        check("rst_card_out", card_out, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 1);
        @(negedge clk);
        check("rst_hold_valid", rsp_valid, 0);
        rst = 0;
        rsp_ready = 0;
        in_sess = 0;
        tries_m = 0;
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            op_done = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (rsp_valid) vcount++;
        end
        op_done = 0;
        check("no_rsp_after_rst", vcount, 0);
        check("post_rst_card_out", card_out, 1);
    endtask

    initial begin
        logic [CW-1:0] cd, cc;
        logic [PW-1:0] ps;
        logic [1:0]    op;
        logic [BW-1:0] vl;

        rst = 1;
        req_valid = 0; req_card = '0; req_psw = '0; req_lang = 0; req_op = '0;
        req_value = '0; req_last = 0; rsp_ready = 0;
        op_done = 0; error = 0; wrong_psw = 0; updated_balance = '0;
        for (int i = 0; i < 8; i++) begin
            bal[i] = BW'($urandom_range(0, 100000));
            pin[i] = PW'($urandom);
        end

        repeat (2) @(negedge clk);
        check("reset_ready", req_ready, 1);
        check("reset_card_out", card_out, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_status", rsp_status, 0);
        check("reset_balance", rsp_balance, 0);
        check("reset_atm_outs", {card_number, password_input, language, operation, value, another_service}, 0);
        rst = 0;

        // Single inquiry, then a two-service session with a different req_card.
        run_req(3, pin[3], 0, OP_INQUIRY, '0, 1, 0, 0, 0);
        run_req(3, pin[3], 1, OP_DEPOSIT, 100, 0, 0, 2, 1);
        run_req(5, pin[3], 0, OP_INQUIRY, '0, 1, 0, 1, 0);
        // Wrong PIN three times forces eject even though last=0.
        for (int i = 0; i < MAXT; i++)
            run_req(3, pin[3] ^ 4'h1, 0, OP_INQUIRY, '0, 0, 0, i, 0);
        // No ATM answer at all.
        run_req(3, pin[3], 0, OP_INQUIRY, '0, 0, 1, 0, 0);
        // Overdraw: error with op_done, plus 5 cycles of back-pressure.
        run_req(3, pin[3], 0, OP_WITHDRAW, bal[3] + 1, 1, 0, 0, 5);
        reset_mid_wait(3);

        for (int n = 0; n < 40; n++) begin
            cd = CW'($urandom);
            cc = cur_card(cd);
            ps = ($urandom_range(0, 3) == 0) ? (pin[cc] ^ PW'($urandom_range(1, 15))) : pin[cc];
            op = 2'($urandom_range(0, 2));
            vl = (op == OP_WITHDRAW) ? BW'($urandom_range(0, 150000)) : BW'($urandom_range(0, 5000));
            run_req(cd, ps, 1'($urandom_range(0, 1)), op, vl,
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
                    $urandom_range(0, 6), $urandom_range(0, 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
